// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - display data load bus (shadow capture strobe, payload, acknowledge)
interface disp_scan_ctrl_if;
   logic        load;
   logic [31:0] hexs_in;
   logic [7:0]  point_in;
   logic [7:0]  les_in;
   logic        load_ack;

   modport master (output load, hexs_in, point_in, les_in, input load_ack);
   modport slave  (input load, hexs_in, point_in, les_in, output load_ack);
endinterface

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 8-digit display scan sequencer with blanking gap and frame-synchronous double buffer
module disp_scan_ctrl #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               scan_all,
   input  logic               page,
   disp_scan_ctrl_if.slave    load_bus,
   output logic [2:0]         Scan,
   output logic [31:0]        Hexs,
   output logic [7:0]         point,
   output logic [7:0]         LES,
   output logic               blank,
   output logic               frame_done
);
   localparam int CW = $clog2(DIV > BLANK_CYC ? DIV : BLANK_CYC);
   localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    scan_nx;
   logic          page_r, page_nx;
   logic          all_r, all_nx;
   logic [31:0]   sh_hexs;
   logic [7:0]    sh_point, sh_les;
   logic          pend, pend_nx;
   logic          adv, wrap, apply;
   logic          ack_q;

   assign load_bus.load_ack = ack_q;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      scan_nx  = Scan;
      page_nx  = page_r;
      all_nx   = all_r;
      adv      = 1'b0;
      if (!en) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = SHOW;
               cnt_nx   = '0;
            end
            SHOW: begin
               if (cnt == DIV_LAST) begin
                  state_nx = BLANK;
                  cnt_nx   = '0;
                  adv      = 1'b1;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_nx = SHOW;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
      // Mode and page are resampled only at the wrap, so the first digit of a new frame uses them directly
      wrap = adv && (all_r ? (Scan == 3'd7) : (Scan[1:0] == 2'b11));
      if (wrap) begin
         all_nx  = scan_all;
         page_nx = page;
         scan_nx = scan_all ? 3'd0 : {page, 2'b00};
      end else if (adv) begin
         scan_nx = all_r ? Scan + 3'd1 : {page_r, Scan[1:0] + 2'd1};
      end
      apply   = wrap && pend;
      pend_nx = load_bus.load | (pend & ~apply);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         Scan       <= 3'd0;
         page_r     <= 1'b0;
         all_r      <= 1'b1;
         Hexs       <= '0;
         point      <= '0;
         LES        <= '0;
         sh_hexs    <= '0;
         sh_point   <= '0;
         sh_les     <= '0;
         pend       <= 1'b0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         Scan       <= scan_nx;
         page_r     <= page_nx;
         all_r      <= all_nx;
         pend       <= pend_nx;
         blank      <= (state_nx != SHOW);
         frame_done <= wrap;
         ack_q      <= apply;
         if (apply) begin
            Hexs  <= sh_hexs;
            point <= sh_point;
            LES   <= sh_les;
         end
         // A load on the wrap edge lands after the old shadow was copied out
         if (load_bus.load) begin
            sh_hexs  <= load_bus.hexs_in;
            sh_point <= load_bus.point_in;
            sh_les   <= load_bus.les_in;
         end
      end
   end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - randomized self-checking bench for disp_scan_ctrl against a phase-position model
module tb_disp_scan_ctrl;
   localparam int DIV = 4;
   localparam int BLK = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_en = 1'b0, i_sa = 1'b1, i_pg = 1'b0;
   logic [2:0]  Scan;
   logic [31:0] Hexs;
   logic [7:0]  point, LES;
   logic        blank, frame_done;

   int n_checks = 0;
   int n_errors = 0;

   disp_scan_ctrl_if lif ();

   disp_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLK)) dut (
      .clk(clk), .rst_n(rst_n), .en(i_en), .scan_all(i_sa), .page(i_pg),
      .load_bus(lif.master), .Scan(Scan), .Hexs(Hexs), .point(point), .LES(LES),
      .blank(blank), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // model: position within the digit period (0..DIV-1 unblanked, DIV..DIV+BLK-1 blanked)
   int          m_p, m_scan;
   bit          m_idle, m_all, m_page, m_pend, m_fd, m_ack;
   logic [31:0] m_hexs, s_hexs;
   logic [7:0]  m_pt, s_pt, m_les, s_les;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_p = 0; m_scan = 0; m_idle = 1; m_all = 1; m_page = 0; m_pend = 0;
      m_fd = 0; m_ack = 0; m_hexs = 0; s_hexs = 0; m_pt = 0; s_pt = 0; m_les = 0; s_les = 0;
   endtask

   task automatic compare_all();
      check("scan", {29'd0, Scan}, m_scan);
      check("blank", {31'd0, blank}, (m_idle || m_p >= DIV) ? 1 : 0);
      check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
      check("load_ack", {31'd0, lif.load_ack}, {31'd0, m_ack});
      check("hexs", Hexs, m_hexs);
      check("point", {24'd0, point}, {24'd0, m_pt});
      check("les", {24'd0, LES}, {24'd0, m_les});
   endtask

   task automatic tick();
      bit w;
      @(posedge clk);
      m_fd = 0; m_ack = 0;
      if (!i_en) begin
         m_idle = 1; m_p = 0;
      end else if (m_idle) begin
         m_idle = 0; m_p = 0;
      end else if (m_p == DIV - 1) begin
         w = m_all ? (m_scan == 7) : (m_scan % 4 == 3);
         if (w) begin
            m_all = i_sa; m_page = i_pg;
            m_scan = i_sa ? 0 : 4 * int'(i_pg);
            m_fd = 1;
            if (m_pend) begin
               m_hexs = s_hexs; m_pt = s_pt; m_les = s_les; m_pend = 0; m_ack = 1;
            end
         end else begin
            m_scan = m_all ? (m_scan + 1) % 8 : 4 * int'(m_page) + (m_scan % 4) + 1;
         end
         m_p = DIV;
      end else if (m_p == DIV + BLK - 1) begin
         m_p = 0;
      end else begin
         m_p++;
      end
      if (lif.load) begin
         s_hexs = lif.hexs_in; s_pt = lif.point_in; s_les = lif.les_in; m_pend = 1;
      end
      #1;
      compare_all();
      lif.load = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] h);
      lif.load = 1'b1; lif.hexs_in = h; lif.point_in = h[7:0] ^ 8'h5a; lif.les_in = h[15:8];
      tick();
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      while (!lif.load_ack && n < 200) begin tick(); n++; end
      check(tag, {31'd0, lif.load_ack}, 1);
   endtask

   initial begin
      int cnt, n;
      lif.load = 1'b0; lif.hexs_in = '0; lif.point_in = '0; lif.les_in = '0;
      model_reset();
      #12;
      compare_all();
      #5 rst_n = 1'b1;

      // full 8-digit frame from reset
      i_en = 1'b1; i_sa = 1'b1;
      cnt = 0;
      for (int i = 0; i < 49; i++) begin tick(); if (frame_done) cnt++; end
      check("fd_per_frame", cnt, 1);

      // page mode switch mid-frame, then back to page 0
      i_sa = 1'b0; i_pg = 1'b1;
      for (int i = 0; i < 60; i++) tick();
      check("page1_scan", {31'd0, Scan[2]}, 1);
      i_pg = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      check("page0_scan", {31'd0, Scan[2]}, 0);

      // load while digit 3 is shown
      i_sa = 1'b1;
      n = 0;
      while (!(m_scan == 3 && m_p < DIV && !m_idle) && n < 200) begin tick(); n++; end
      do_load(32'h89ABCDEF);
      check("hexs_held", Hexs, 32'h0);
      wait_ack("ack_first");
      check("hexs_new", Hexs, 32'h89ABCDEF);
      check("hexs_under_blank", {31'd0, blank}, 1);
      check("scan_at_wrap", {29'd0, Scan}, 0);

      // last load wins
      do_load(32'h11111111);
      tick();
      do_load(32'h22222222);
      wait_ack("ack_last_wins");
      check("last_wins", Hexs, 32'h22222222);

      // load coincident with the wrap edge
      do_load(32'h44444444);
      n = 0;
      while (!(m_p == DIV - 1 && m_scan == 7 && !m_idle) && n < 200) begin tick(); n++; end
      do_load(32'h33333333);
      check("wrap_old_shadow", Hexs, 32'h44444444);
      tick();
      wait_ack("ack_wrap_load");
      check("wrap_new_shadow", Hexs, 32'h33333333);

      // disable during digit 5 SHOW
      n = 0;
      while (!(m_scan == 5 && m_p == 1 && !m_idle) && n < 200) begin tick(); n++; end
      i_en = 1'b0;
      tick();
      check("dis_blank", {31'd0, blank}, 1);
      check("dis_scan", {29'd0, Scan}, 5);
      tick(); tick();
      i_en = 1'b1;
      cnt = 0; n = 0;
      while (Scan == 3'd5 && n < 20) begin tick(); if (!blank && Scan == 3'd5) cnt++; n++; end
      check("reen_show_len", cnt, DIV);
      check("reen_next", {29'd0, Scan}, 6);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         i_en = ($urandom % 40) != 0;
         if ($urandom % 150 == 0) i_sa = ~i_sa;
         if ($urandom % 60 == 0) i_pg = ~i_pg;
         if ($urandom % 25 == 0) begin
            lif.load = 1'b1; lif.hexs_in = $urandom;
            lif.point_in = 8'($urandom); lif.les_in = 8'($urandom);
         end
         tick();
      end

      // asynchronous reset in BLANK with data pending
      i_en = 1'b1;
      do_load(32'hA5A5A5A5);
      n = 0;
      while (!(m_p >= DIV && !m_idle) && n < 200) begin tick(); n++; end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      #2 rst_n = 1'b1;
      i_sa = 1'b1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin tick(); if (lif.load_ack) cnt++; end
      check("pend_cleared", cnt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan sequencer that drives the 8-digit hex display multiplexer. It generates the 3-bit digit index `Scan` from a programmable prescaler and inserts a blanking gap between digits to suppress ghosting. It also double-buffers the display data (`Hexs`, `point`, `LES`) so that content changes only at frame boundaries. It sits directly upstream of the scan/sync mux, which consumes `Scan`, `Hexs`, `point` and `LES`; `blank` is ANDed into the anode enables downstream.

## Interface
Parameters:
- `DIV`, 50000: SHOW-phase length per digit, in clk cycles (≥2).
- `BLANK_CYC`, 4: BLANK-phase length per digit, in clk cycles (≥1).

Ports:
- `clk`  in  1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n`  in  1: asynchronous active-low reset.
- `en`  in  1: scan enable.
- `scan_all`  in  1: 1 = cycle digits 0..7; 0 = cycle the 4 digits of one page.
- `page`  in  1: page select when `scan_all`=0 (digits {page,2'b00}..{page,2'b11}).
- `load`  in  1: one-cycle strobe; captures `hexs_in`/`point_in`/`les_in` into the shadow register.
- `hexs_in`  in  32: new digit nibbles, digit k = [4k+3:4k].
- `point_in`  in  8: new decimal-point bits.
- `les_in`  in  8: new LE bits.
- `Scan`  out  3: current digit index.
- `Hexs`  out  32: active display data.
- `point`  out  8: active point bits.
- `LES`  out  8: active LE bits.
- `blank`  out  1: 1 = all anodes must be off.
- `frame_done`  out  1: one-cycle pulse after each frame wrap.
- `load_ack`  out  1: one-cycle pulse when pending shadow data becomes active.

## Operation
- FSM states: IDLE, SHOW, BLANK. Reset → IDLE.
- IDLE: `blank`=1. `Scan` holds. Prescaler and blank counters are 0. When `en`=1, the next edge moves to SHOW.
- SHOW: `blank`=0. The prescaler counts 0..DIV-1. On the edge where the count equals DIV-1:
  - state → BLANK;
  - `Scan` ← next index;
  - prescaler ← 0.
- BLANK: `blank`=1. The counter counts 0..BLANK_CYC-1, then state → SHOW. `Scan` is stable throughout.
- Next index:
  - `scan_all`=1: Scan+1 mod 8.
  - `scan_all`=0: {page_r, Scan[1:0]+1}. `page_r` is `page` registered only at a frame wrap.
- Frame wrap: the advance from index 7 (`scan_all`=1) or from low bits 2'b11 (`scan_all`=0).
  - At the wrap edge, `page_r` ← `page`.
  - If the pending flag is set, active data ← shadow, pending ← 0, and `load_ack` pulses.
  - Because the wrap edge enters BLANK, new data always appears under blanking.
- `scan_all` and `page` changes take effect only at a frame wrap. `scan_all` is also sampled then.
- `load`: shadow ← inputs; pending ← 1. Repeated loads before a wrap overwrite the shadow (last wins).
- `load` coincident with a wrap edge: the wrap copies the old shadow, then the new data is captured and pending stays 1. It becomes active at the following wrap.
- `en`=0 in any state: the next edge → IDLE (`blank`=1, counters cleared, `Scan` and data held, pending kept).
- Reset values: `Scan`=0, `Hexs`=0, `point`=0, `LES`=0, shadow=0, pending=0, `page_r`=0, `blank`=1, `frame_done`=0, `load_ack`=0.
- Asynchronous reset mid-frame forces all reset values immediately.

## Timing
- Digit period = DIV + BLANK_CYC cycles. Frame = 8 or 4 digit periods.
- All outputs are registered; there is no combinational input→output path.
- `Scan` changes on the same edge that `blank` rises. `blank` falls BLANK_CYC cycles later.
- `frame_done` and `load_ack` are high during the first BLANK cycle after the wrap edge.
- `en` rising: the first SHOW cycle is 1 cycle later, with `Scan` unchanged.

## Test plan
(DIV=4, BLANK_CYC=2)
- Reset, then `en`=1, `scan_all`=1 → `Scan` sequence 0,1,…,7,0. Each digit is unblanked exactly 4 cycles and blanked 2. `frame_done` pulses once per 48 cycles, on the entry into digit 0's blank.
- `scan_all`=0, `page`=1 set mid-frame → the current frame continues; after the wrap, `Scan` runs 4,5,6,7,4. `page`→0 mid-page → 0..3 only after the next wrap.
- `load` with `hexs_in`=32'h89ABCDEF while `Scan`=3 → `Hexs` stays 0 until the 7→0 wrap edge, then becomes 89ABCDEF with `blank`=1. `load_ack` pulses once.
- Two loads (11111111, then 22222222) within one frame → only 22222222 becomes active. `load` on the exact wrap edge → old shadow is applied, the new value applies at the next wrap.
- `en`=0 during SHOW at `Scan`=5 → `blank`=1 the next cycle and `Scan` holds 5. Re-enable → 4 SHOW cycles at 5, then 6.
- Assert `rst_n`=0 mid-BLANK → `Scan`=0, `Hexs`=0, `blank`=1, and pending cleared immediately.
